// File: rtl/cprv_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : cprv_fetch_unit
//  Purpose  : Instruction fetch for the cprv64g pipeline. Generates sequential
//             PCs, keeps up to MAX_OUTSTANDING imem requests in flight and
//             buffers returned instructions (with PCs) toward decode.
//             A redirect restarts fetch, flushes the buffer and marks every
//             in-flight request stale so its response is discarded.
//  Revision : 1.0  initial release
// ============================================================================
module cprv_fetch_unit #(
  parameter int                    INSTR_WIDTH     = 32,
  parameter int                    DATA_WIDTH      = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_PC        = '0,
  parameter int                    FIFO_DEPTH      = 4,
  parameter int                    MAX_OUTSTANDING = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   valid_imem_o,
  input  logic                   ready_imem_i,
  output logic [DATA_WIDTH-1:0]  instr_addr_imem_o,
  input  logic                   valid_if_i,
  output logic                   ready_if_o,
  input  logic [DATA_WIDTH-1:0]  instr_data_imem_i,
  input  logic                   redirect_valid_i,
  input  logic [DATA_WIDTH-1:0]  redirect_pc_i,
  output logic                   valid_id_o,
  input  logic                   ready_id_i,
  output logic [INSTR_WIDTH-1:0] instr_data_id_o,
  output logic [DATA_WIDTH-1:0]  instr_pc_id_o
);

  localparam int c_FQ_AW  = $clog2(FIFO_DEPTH);
  localparam int c_FQ_CW  = $clog2(FIFO_DEPTH + 1);
  localparam int c_IF_AW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int c_IF_CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int c_SUM_W  = ((c_IF_CW > c_FQ_CW) ? c_IF_CW : c_FQ_CW) + 1;

  localparam logic [c_IF_CW-1:0]    c_IF_MAX   = c_IF_CW'(MAX_OUTSTANDING);
  localparam logic [c_IF_AW-1:0]    c_IF_LAST  = c_IF_AW'(MAX_OUTSTANDING - 1);
  localparam logic [c_SUM_W-1:0]    c_FQ_LIMIT = c_SUM_W'(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] c_PC_STEP  = DATA_WIDTH'(4);

  // Fetch PC and in-flight request queue (each entry {pc, stale})
  logic [DATA_WIDTH-1:0]      r_pc;
  logic [DATA_WIDTH-1:0]      r_if_pc [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] r_if_stale;
  logic [c_IF_AW-1:0]         r_if_wr;
  logic [c_IF_AW-1:0]         r_if_rd;
  logic [c_IF_CW-1:0]         r_if_cnt;

  // Instruction buffer toward decode (each entry {instr, pc})
  logic [INSTR_WIDTH-1:0]     r_fq_instr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]      r_fq_pc    [FIFO_DEPTH];
  logic [c_FQ_AW-1:0]         r_fq_wr;
  logic [c_FQ_AW-1:0]         r_fq_rd;
  logic [c_FQ_CW-1:0]         r_fq_cnt;

  logic [c_SUM_W-1:0]         w_credit_used;
  logic                       w_req_fire;
  logic                       w_rsp_fire;
  logic [DATA_WIDTH-1:0]      w_head_pc;
  logic                       w_head_stale;
  logic [INSTR_WIDTH-1:0]     w_sel;
  logic                       w_fq_push;
  logic                       w_fq_pop;
  logic [c_IF_AW-1:0]         w_if_wr_nxt;
  logic [c_IF_AW-1:0]         w_if_rd_nxt;
  logic                       w_unused;

  // Stale requests still hold a FIFO slot reservation until they return,
  // so the credit check uses registered counts only.
  assign w_credit_used     = c_SUM_W'(r_if_cnt) + c_SUM_W'(r_fq_cnt);
  assign valid_imem_o      = ~rst & (r_if_cnt < c_IF_MAX) & (w_credit_used < c_FQ_LIMIT);
  assign instr_addr_imem_o = r_pc;
  assign ready_if_o        = ~rst;

  assign w_req_fire   = valid_imem_o & ready_imem_i;
  assign w_rsp_fire   = valid_if_i & ready_if_o & (r_if_cnt != '0);
  assign w_head_pc    = r_if_pc[r_if_rd];
  assign w_head_stale = r_if_stale[r_if_rd];
  // imem returns the aligned 8-byte word; PC bit 2 picks the half
  assign w_sel        = w_head_pc[2] ? instr_data_imem_i[2*INSTR_WIDTH-1:INSTR_WIDTH]
                                     : instr_data_imem_i[INSTR_WIDTH-1:0];
  assign w_fq_push    = w_rsp_fire & ~w_head_stale & ~redirect_valid_i;

  assign valid_id_o      = (r_fq_cnt != '0) & ~redirect_valid_i;
  assign w_fq_pop        = valid_id_o & ready_id_i;
  assign instr_data_id_o = r_fq_instr[r_fq_rd];
  assign instr_pc_id_o   = r_fq_pc[r_fq_rd];

  // In-flight pointers wrap explicitly so MAX_OUTSTANDING = 1 also works
  assign w_if_wr_nxt = (r_if_wr == c_IF_LAST) ? '0 : r_if_wr + c_IF_AW'(1);
  assign w_if_rd_nxt = (r_if_rd == c_IF_LAST) ? '0 : r_if_rd + c_IF_AW'(1);

  // Redirect targets are word aligned; the low bits are dropped on purpose
  assign w_unused = ^redirect_pc_i[1:0];

  // Control state: PC, queue pointers/counts, stale tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_if_wr    <= '0;
      r_if_rd    <= '0;
      r_if_cnt   <= '0;
      r_if_stale <= '0;
      r_fq_wr    <= '0;
      r_fq_rd    <= '0;
      r_fq_cnt   <= '0;
    end else begin
      if (redirect_valid_i)
        r_pc <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
      else if (w_req_fire)
        r_pc <= r_pc + c_PC_STEP;

      // A redirect poisons everything in flight, including a same-cycle push
      if (redirect_valid_i)
        r_if_stale <= '1;
      else if (w_req_fire)
        r_if_stale[r_if_wr] <= 1'b0;

      if (w_req_fire) r_if_wr <= w_if_wr_nxt;
      if (w_rsp_fire) r_if_rd <= w_if_rd_nxt;
      case ({w_req_fire, w_rsp_fire})
        2'b10:   r_if_cnt <= r_if_cnt + c_IF_CW'(1);
        2'b01:   r_if_cnt <= r_if_cnt - c_IF_CW'(1);
        default: ;
      endcase

      if (redirect_valid_i) begin
        r_fq_wr  <= '0;
        r_fq_rd  <= '0;
        r_fq_cnt <= '0;
      end else begin
        if (w_fq_push) r_fq_wr <= r_fq_wr + c_FQ_AW'(1);
        if (w_fq_pop)  r_fq_rd <= r_fq_rd + c_FQ_AW'(1);
        case ({w_fq_push, w_fq_pop})
          2'b10:   r_fq_cnt <= r_fq_cnt + c_FQ_CW'(1);
          2'b01:   r_fq_cnt <= r_fq_cnt - c_FQ_CW'(1);
          default: ;
        endcase
      end
    end
  end

  // Queue payload storage; contents are qualified by the counts, no reset needed
  always_ff @(posedge clk) begin
    if (w_req_fire)
      r_if_pc[r_if_wr] <= r_pc;
    if (w_fq_push) begin
      r_fq_instr[r_fq_wr] <= w_sel;
      r_fq_pc[r_fq_wr]    <= w_head_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cprv_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cprv_fetch_unit
//  Purpose  : Scoreboard bench for cprv_fetch_unit with a behavioural imem.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cprv_fetch_unit;

  localparam logic [63:0] c_RESET_PC = 64'h0;

  logic        clk;
  logic        rst;
  logic        valid_imem_o;
  logic        ready_imem_i;
  logic [63:0] instr_addr_imem_o;
  logic        valid_if_i;
  logic        ready_if_o;
  logic [63:0] instr_data_imem_i;
  logic        redirect_valid_i;
  logic [63:0] redirect_pc_i;
  logic        valid_id_o;
  logic        ready_id_i;
  logic [31:0] instr_data_id_o;
  logic [63:0] instr_pc_id_o;

  cprv_fetch_unit dut (
    .clk               (clk),
    .rst               (rst),
    .valid_imem_o      (valid_imem_o),
    .ready_imem_i      (ready_imem_i),
    .instr_addr_imem_o (instr_addr_imem_o),
    .valid_if_i        (valid_if_i),
    .ready_if_o        (ready_if_o),
    .instr_data_imem_i (instr_data_imem_i),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_pc_i     (redirect_pc_i),
    .valid_id_o        (valid_id_o),
    .ready_id_i        (ready_id_i),
    .instr_data_id_o   (instr_data_id_o),
    .instr_pc_id_o     (instr_pc_id_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] instr;
  } exp_t;

  exp_t        sb[$];      // expected ID stream
  logic [63:0] imq[$];     // requests accepted by the imem model, awaiting response
  logic [63:0] exp_pc;
  bit          rsp_en;
  int          n_cmp;
  int          n_err;
  int          n_req;
  int          n_id;

  // Memory contents: distinct low/high halves derived from the word address
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    logic [31:0] w;
    w = a[31:0] & 32'hFFFF_FFF8;
    return {w * 32'd5 + 32'h9876_0000, w * 32'd3 + 32'h0000_1234};
  endfunction

  function automatic logic [63:0] exp_instr(input logic [63:0] pc);
    logic [63:0] d;
    d = mem_word(pc);
    return pc[2] ? {32'h0, d[63:32]} : {32'h0, d[31:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs, advance, update the models, drive imem response
  task automatic tick();
    bit   req_f, rsp_f, id_f, redir;
    exp_t e;
    #1;
    req_f = !rst && valid_imem_o && ready_imem_i;
    rsp_f = valid_if_i;
    id_f  = !rst && valid_id_o && ready_id_i;
    redir = redirect_valid_i;
    if (!rst && valid_imem_o) check_eq("req_addr", instr_addr_imem_o, exp_pc);
    if (!rst && redir)        check_eq("id_masked", {63'h0, valid_id_o}, 64'h0);
    if (id_f) begin
      if (sb.size() == 0) begin
        check_eq("id_unexpected", {63'h0, valid_id_o}, 64'h0);
      end else begin
        e = sb.pop_front();
        check_eq("id_pc", instr_pc_id_o, e.pc);
        check_eq("id_instr", {32'h0, instr_data_id_o}, e.instr);
        n_id++;
      end
    end
    @(posedge clk);
    if (rst) begin
      sb.delete();
      imq.delete();
      exp_pc = c_RESET_PC;
    end else begin
      if (rsp_f && imq.size() != 0) void'(imq.pop_front());
      if (req_f) begin
        imq.push_back(exp_pc);
        if (!redir) begin
          e.pc    = exp_pc;
          e.instr = exp_instr(exp_pc);
          sb.push_back(e);
        end
        exp_pc = exp_pc + 64'd4;
        n_req++;
      end
      if (redir) begin
        sb.delete();
        exp_pc = redirect_pc_i & ~64'h3;
      end
    end
    @(negedge clk);
    valid_if_i        = rsp_en && !rst && (imq.size() != 0);
    instr_data_imem_i = (imq.size() != 0) ? mem_word(imq[0]) : 64'h0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int base;
    n_cmp = 0; n_err = 0; n_req = 0; n_id = 0;
    exp_pc            = c_RESET_PC;
    rsp_en            = 1'b1;
    rst               = 1'b1;
    ready_imem_i      = 1'b1;
    ready_id_i        = 1'b1;
    valid_if_i        = 1'b0;
    instr_data_imem_i = 64'h0;
    redirect_valid_i  = 1'b0;
    redirect_pc_i     = 64'h0;

    // Reset values
    ticks(3);
    #1;
    check_eq("rst_valid_imem", {63'h0, valid_imem_o}, 64'h0);
    check_eq("rst_ready_if", {63'h0, ready_if_o}, 64'h0);
    check_eq("rst_valid_id", {63'h0, valid_id_o}, 64'h0);
    check_eq("rst_addr", instr_addr_imem_o, c_RESET_PC);

    // Streaming with 1-cycle imem, one instruction per cycle
    rst = 1'b0;
    #1;
    check_eq("first_valid_imem", {63'h0, valid_imem_o}, 64'h1);
    check_eq("first_addr", instr_addr_imem_o, c_RESET_PC);
    check_eq("ready_if", {63'h0, ready_if_o}, 64'h1);
    ticks(2);
    base = n_id;
    ticks(10);
    check_eq("throughput", 64'(n_id - base), 64'd10);

    // Redirect with two requests in flight
    rst = 1'b1; ticks(1); rst = 1'b0;
    rsp_en = 1'b0;
    ticks(2);
    #1;
    check_eq("two_inflight_block", {63'h0, valid_imem_o}, 64'h0);
    rsp_en = 1'b1;
    redirect_valid_i = 1'b1; redirect_pc_i = 64'h1002;
    tick();
    redirect_valid_i = 1'b0;
    #1;
    check_eq("redir_addr", instr_addr_imem_o, 64'h1000);
    base = n_id;
    ticks(8);
    check_eq("redir_stream", 64'(n_id > base), 64'h1);

    // Redirect coinciding with a request handshake and a response
    #1;
    check_eq("redir2_setup", {62'h0, valid_imem_o, valid_if_i}, 64'h3);
    redirect_valid_i = 1'b1; redirect_pc_i = 64'h2000;
    tick();
    redirect_valid_i = 1'b0;
    #1;
    check_eq("redir2_addr", instr_addr_imem_o, 64'h2000);
    ticks(6);

    // imem stall: request held, address stable
    ready_imem_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      check_eq("stall_valid", {63'h0, valid_imem_o}, 64'h1);
      check_eq("stall_addr", instr_addr_imem_o, exp_pc);
    end
    ready_imem_i = 1'b1;
    ticks(6);

    // Back-pressure from ID: exactly FIFO_DEPTH requests then stop
    rst = 1'b1; ticks(1); rst = 1'b0;
    ready_id_i = 1'b0;
    base = n_req;
    ticks(10);
    #1;
    check_eq("bp_requests", 64'(n_req - base), 64'd4);
    check_eq("bp_valid_imem", {63'h0, valid_imem_o}, 64'h0);
    check_eq("bp_valid_id", {63'h0, valid_id_o}, 64'h1);
    ready_id_i = 1'b1;
    base = n_id;
    #1;
    check_eq("resume_addr", instr_addr_imem_o, 64'h10);
    ticks(4);
    check_eq("bp_drain", 64'(n_id - base), 64'd4);
    ticks(6);

    // Reset while the buffer is full
    ready_id_i = 1'b0;
    ticks(6);
    rst = 1'b1;
    tick();
    #1;
    check_eq("mid_rst_valid_id", {63'h0, valid_id_o}, 64'h0);
    check_eq("mid_rst_addr", instr_addr_imem_o, c_RESET_PC);
    check_eq("mid_rst_valid_imem", {63'h0, valid_imem_o}, 64'h0);
    rst = 1'b0;
    ready_id_i = 1'b1;
    #1;
    check_eq("post_rst_valid_imem", {63'h0, valid_imem_o}, 64'h1);
    ticks(10);

    // Stop fetching and let everything drain
    ready_imem_i = 1'b0;
    ticks(8);
    check_eq("sb_drained", 64'(sb.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
